jk_cmd_driver: RTL and testbench

JK_CMD_DRIVER -- requirements
Module: jk_cmd_driver

---
 rtl/jk_cmd_driver.sv | 164 ++++++++++++++++
 tb/tb_jk_cmd_driver.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_driver.sv
// Command FIFO feeding a J/K drive sequencer for an external JK flip-flop.
// Each command is driven for one cycle, then the flip-flop's Q is checked.
module jk_cmd_driver #(
   parameter int DEPTH = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_cmd_valid,
   input  logic [1:0] i_cmd,
   output logic       o_cmd_ready,
   output logic       o_j,
   output logic       o_k,
   input  logic       i_q,
   input  logic       i_err_clr,
   output logic       o_busy,
   output logic       o_err,
   output logic [7:0] o_err_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_CHECK
   } state_e;

   typedef enum logic [1:0] {
      CMD_HOLD   = 2'b00,
      CMD_RESET  = 2'b01,
      CMD_SET    = 2'b10,
      CMD_TOGGLE = 2'b11
   } cmd_e;

   logic [1:0]  mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   state_e      state_q, state_d;
   cmd_e        cmd_q, cmd_d;
   logic        q_prev_q, q_prev_d;
   logic        q_known_q, q_known_d;
   logic        j_q, j_d;
   logic        k_q, k_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        full;
   logic        empty;
   logic        push;
   cmd_e        head_cmd;
   logic        exp_q;
   logic        do_check;
   logic        mismatch;

   // The extra pointer MSB distinguishes full from empty when the indices match.
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push     = i_cmd_valid && !full;
   assign head_cmd = cmd_e'(mem_q[rd_ptr_q[AW-1:0]]);

   always_comb begin
      exp_q = q_prev_q;
      case (cmd_q)
         CMD_HOLD:   exp_q = q_prev_q;
         CMD_RESET:  exp_q = 1'b0;
         CMD_SET:    exp_q = 1'b1;
         CMD_TOGGLE: exp_q = ~q_prev_q;
         default:    exp_q = q_prev_q;
      endcase
   end

   // NOTE: every combinational output gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      cmd_d     = cmd_q;
      q_prev_d  = q_prev_q;
      q_known_d = q_known_q;
      j_d       = 1'b0;
      k_d       = 1'b0;
      do_check  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               rd_ptr_d   = rd_ptr_q + (AW+1)'(1);
               cmd_d      = head_cmd;
               q_prev_d   = i_q;
               {j_d, k_d} = head_cmd;
               state_d    = ST_DRIVE;
            end
         end
         ST_DRIVE: state_d = ST_CHECK;
         ST_CHECK: begin
            state_d = ST_IDLE;
            // Hold/toggle expectations depend on q_prev, meaningless until Q is known.
            if (cmd_q == CMD_SET || cmd_q == CMD_RESET) begin
               do_check  = 1'b1;
               q_known_d = 1'b1;
            end else begin
               do_check  = q_known_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      mismatch = do_check && (i_q != exp_q);

      err_d = err_q;
      cnt_d = cnt_q;
      if (mismatch) begin
         err_d = 1'b1;
         if (i_err_clr)          cnt_d = 8'd1;
         else if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end else if (i_err_clr) begin
         err_d = 1'b0;
         cnt_d = 8'd0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cmd_q     <= CMD_HOLD;
         q_prev_q  <= 1'b0;
         q_known_q <= 1'b0;
         j_q       <= 1'b0;
         k_q       <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= 8'd0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cmd_q     <= cmd_d;
         q_prev_q  <= q_prev_d;
         q_known_q <= q_known_d;
         j_q       <= j_d;
         k_q       <= k_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end

   // NOTE: storage is not reset; emptiness is tracked by the pointers alone.
   always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= i_cmd;
   end

   assign o_cmd_ready = !full;
   assign o_j         = j_q;
   assign o_k         = k_q;
   assign o_busy      = !empty || (state_q != ST_IDLE);
   assign o_err       = err_q;
   assign o_err_cnt   = cnt_q;

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Directed bench for jk_cmd_driver with a behavioural JK flip-flop on the outputs.
module tb_jk_cmd_driver;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic [1:0] cmd;
   logic       cmd_ready;
   logic       j, k;
   logic       q;
   logic       err_clr;
   logic       busy;
   logic       err;
   logic [7:0] err_cnt;

   logic       ff_q;
   logic       stuck;

   int n_vec  = 0;
   int n_fail = 0;

   jk_cmd_driver #(.DEPTH(DEPTH)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_cmd_valid(cmd_valid),
      .i_cmd      (cmd),
      .o_cmd_ready(cmd_ready),
      .o_j        (j),
      .o_k        (k),
      .i_q        (q),
      .i_err_clr  (err_clr),
      .o_busy     (busy),
      .o_err      (err),
      .o_err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   // Downstream JK flip-flop; 'stuck' forces its Q output low.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff_q <= 1'b0;
      else begin
         case ({j, k})
            2'b01:   ff_q <= 1'b0;
            2'b10:   ff_q <= 1'b1;
            2'b11:   ff_q <= ~ff_q;
            default: ff_q <= ff_q;
         endcase
      end
   end
   assign q = stuck ? 1'b0 : ff_q;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      n_vec++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s drain timeout: busy=%b want 0", name, busy);
      end
   endtask

   // Push one command into an idle driver and run to the edge after its check.
   task automatic push_cmd(input logic [1:0] c, input logic clr_at_check);
      cmd_valid = 1'b1;
      cmd       = c;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      err_clr = clr_at_check;
      tick();
      err_clr = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd = 2'b00;
      err_clr = 1'b0;
      stuck = 1'b0;
      #12;
      n_vec++;
      if ({cmd_ready, j, k, busy, err, err_cnt} !== {4'b1000, 1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL reset_state: rdy/j/k/busy/err/cnt=%b%b%b%b%b/%0d want 10000/0",
                  cmd_ready, j, k, busy, err, err_cnt);
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_set();
      logic [1:0] exp_jk [4] = '{2'b00, 2'b10, 2'b00, 2'b00};
      cmd_valid = 1'b1;
      cmd = 2'b10;
      for (int i = 0; i < 4; i++) begin
         tick();
         cmd_valid = 1'b0;
         n_vec++;
         if ({j, k} !== exp_jk[i]) begin
            n_fail++;
            $display("FAIL set_jk[%0d]: jk=%b want %b", i, {j, k}, exp_jk[i]);
         end
      end
      n_vec++;
      if ({busy, err, q} !== 3'b001) begin
         n_fail++;
         $display("FAIL set_done: busy/err/q=%b%b%b want 001", busy, err, q);
      end
   endtask

   task automatic test_toggle_seq();
      logic [1:0] cmds [3] = '{2'b11, 2'b11, 2'b00};
      logic [1:0] exp_jk [9] = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b00,
                                 2'b00, 2'b00, 2'b00, 2'b00};
      logic       exp_busy [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
      cmd_valid = 1'b1;
      cmd = cmds[0];
      tick();
      for (int i = 0; i < 9; i++) begin
         if (i < 2) begin
            cmd_valid = 1'b1;
            cmd = cmds[i+1];
         end else begin
            cmd_valid = 1'b0;
         end
         tick();
         n_vec++;
         if ({j, k} !== exp_jk[i] || busy !== exp_busy[i]) begin
            n_fail++;
            $display("FAIL toggle_seq[%0d]: jk=%b busy=%b want jk=%b busy=%b",
                     i, {j, k}, busy, exp_jk[i], exp_busy[i]);
         end
      end
      n_vec++;
      if ({err, q} !== 2'b01) begin
         n_fail++;
         $display("FAIL toggle_seq_end: err/q=%b%b want 01", err, q);
      end
   endtask

   // Offers every cycle outpace one pop per three cycles; the FIFO fills after
   // six accepts and the two toggle offers that follow are dropped.
   task automatic test_overflow();
      int n_set = 0;
      int n_tog = 0;
      for (int i = 0; i < 40; i++) begin
         cmd_valid = (i < 8);
         cmd = (i < 6) ? 2'b10 : 2'b11;
         if (i >= 5 && i <= 8) begin
            n_vec++;
            if (cmd_ready !== (i == 5 || i == 8)) begin
               n_fail++;
               $display("FAIL overflow_ready[%0d]: ready=%b want %b", i, cmd_ready,
                        (i == 5 || i == 8));
            end
         end
         tick();
         if ({j, k} == 2'b10) n_set++;
         if ({j, k} == 2'b11) n_tog++;
      end
      cmd_valid = 1'b0;
      n_vec++;
      if (n_set != 6 || n_tog != 0) begin
         n_fail++;
         $display("FAIL overflow_pulses: set=%0d toggle=%0d want 6/0", n_set, n_tog);
      end
      wait_idle("overflow");
      n_vec++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_err: err=%b want 0", err);
      end
   endtask

   task automatic test_unknown_toggle();
      apply_reset();
      stuck = 1'b1;
      push_cmd(2'b11, 1'b0);
      n_vec++;
      if ({err, err_cnt} !== {1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL unknown_toggle: err=%b cnt=%0d want 0/0", err, err_cnt);
      end
      stuck = 1'b0;
      push_cmd(2'b10, 1'b0);
      stuck = 1'b1;
      push_cmd(2'b11, 1'b0);
      n_vec++;
      if ({err, err_cnt} !== {1'b1, 8'd1}) begin
         n_fail++;
         $display("FAIL known_toggle: err=%b cnt=%0d want 1/1", err, err_cnt);
      end
      push_cmd(2'b10, 1'b1);
      n_vec++;
      if ({err, err_cnt} !== {1'b1, 8'd1}) begin
         n_fail++;
         $display("FAIL clr_vs_mismatch: err=%b cnt=%0d want 1/1", err, err_cnt);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_vec++;
      if ({err, err_cnt} !== {1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL err_clr: err=%b cnt=%0d want 0/0", err, err_cnt);
      end
      stuck = 1'b0;
   endtask

   task automatic test_saturate();
      stuck = 1'b1;
      cmd_valid = 1'b1;
      cmd = 2'b10;
      for (int i = 0; i < 960; i++) begin
         tick();
         if (i == 3) begin
            n_vec++;
            if ({err, err_cnt} !== {1'b1, 8'd1}) begin
               n_fail++;
               $display("FAIL sat_first: err=%b cnt=%0d want 1/1", err, err_cnt);
            end
         end
      end
      cmd_valid = 1'b0;
      wait_idle("saturate");
      n_vec++;
      if ({err, err_cnt} !== {1'b1, 8'd255}) begin
         n_fail++;
         $display("FAIL saturate: err=%b cnt=%0d want 1/255", err, err_cnt);
      end
      stuck = 1'b0;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   task automatic test_reset_mid_drive();
      int pulses = 0;
      cmd_valid = 1'b1;
      cmd = 2'b10;
      for (int i = 0; i < 5; i++) tick();
      cmd_valid = 1'b0;
      n_vec++;
      if ({j, k, busy} !== 3'b101) begin
         n_fail++;
         $display("FAIL mid_drive_pre: jk=%b busy=%b want 10/1", {j, k}, busy);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({j, k, busy, cmd_ready, err} !== 5'b00010) begin
         n_fail++;
         $display("FAIL async_reset: jk=%b busy=%b rdy=%b err=%b want 00/0/1/0",
                  {j, k}, busy, cmd_ready, err);
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (j || k || busy) pulses++;
      end
      n_vec++;
      if (pulses != 0 || err !== 1'b0 || err_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL post_reset_idle: active=%0d err=%b cnt=%0d want 0/0/0",
                  pulses, err, err_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_set();
      test_toggle_seq();
      test_overflow();
      test_unknown_toggle();
      test_saturate();
      test_reset_mid_drive();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
